// File: rtl/reg_ctx_sequencer.sv
// Register-context sequencer: saves R0..R7 to memory or restores them from
// memory, one word per request/acknowledge transaction starting at Base.
module reg_ctx_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Mode,
    input  logic [15:0] Base,
    output logic        Busy,
    output logic        Done,
    output logic [2:0]  RF_SR1,
    input  logic [15:0] RF_SR1_OUT,
    output logic        RF_LD,
    output logic [2:0]  RF_DR,
    output logic [15:0] RF_Bus,
    output logic        MEM_Req,
    output logic        MEM_WE,
    output logic [15:0] MEM_Addr,
    output logic [15:0] MEM_WData,
    input  logic        MEM_Ack,
    input  logic [15:0] MEM_RData,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAVE_REQ = 3'd1,
        RST_REQ  = 3'd2,
        RST_WB   = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [15:0] base;
    logic [15:0] data;
    logic [2:0]  idx_nxt;
    logic [15:0] addr_nxt;

    assign idx_nxt  = idx + 3'd1;
    assign addr_nxt = base + {13'd0, idx_nxt};

    // Memory handshake: MEM_Req with MEM_WE/MEM_Addr/MEM_WData is held unchanged
    // until the single-cycle MEM_Ack; an ack seen while MEM_Req is low is ignored.
    assign MEM_WData = (state == SAVE_REQ) ? RF_SR1_OUT : 16'd0;
    assign RF_Bus    = RF_LD ? data : 16'd0;
    assign dbg_state = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            idx      <= 3'd0;
            base     <= 16'd0;
            data     <= 16'd0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            RF_SR1   <= 3'd0;
            RF_LD    <= 1'b0;
            RF_DR    <= 3'd0;
            MEM_Req  <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_Addr <= 16'd0;
        end else begin
            Done  <= 1'b0;
            RF_LD <= 1'b0;
            RF_DR <= 3'd0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        base     <= Base;
                        idx      <= 3'd0;
                        Busy     <= 1'b1;
                        RF_SR1   <= 3'd0;
                        MEM_Req  <= 1'b1;
                        MEM_Addr <= Base;
                        if (!Mode) begin
                            state  <= SAVE_REQ;
                            MEM_WE <= 1'b1;
                        end else begin
                            state  <= RST_REQ;
                            MEM_WE <= 1'b0;
                        end
                    end
                end
                SAVE_REQ: begin
                    if (MEM_Ack) begin
                        if (idx == 3'd7) begin
                            state    <= DONE;
                            Busy     <= 1'b0;
                            Done     <= 1'b1;
                            RF_SR1   <= 3'd0;
                            MEM_Req  <= 1'b0;
                            MEM_WE   <= 1'b0;
                            MEM_Addr <= 16'd0;
                        end else begin
                            idx      <= idx_nxt;
                            RF_SR1   <= idx_nxt;
                            MEM_Addr <= addr_nxt;
                        end
                    end
                end
                RST_REQ: begin
                    if (MEM_Ack) begin
                        state    <= RST_WB;
                        data     <= MEM_RData;
                        MEM_Req  <= 1'b0;
                        MEM_WE   <= 1'b0;
                        MEM_Addr <= 16'd0;
                        RF_LD    <= 1'b1;
                        RF_DR    <= idx;
                    end
                end
                RST_WB: begin
                    if (idx == 3'd7) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        state    <= RST_REQ;
                        idx      <= idx_nxt;
                        MEM_Req  <= 1'b1;
                        MEM_Addr <= addr_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    Busy     <= 1'b0;
                    RF_SR1   <= 3'd0;
                    MEM_Req  <= 1'b0;
                    MEM_WE   <= 1'b0;
                    MEM_Addr <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Bench for reg_ctx_sequencer: table of save/restore operations against a
// register-file and memory model, plus reset, idle-noise and back-to-back cases.
module tb_reg_ctx_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Start, Mode;
    logic [15:0] Base;
    logic        Busy, Done, RF_LD, MEM_Req, MEM_WE;
    logic [2:0]  RF_SR1, RF_DR, dbg_state;
    logic [15:0] RF_SR1_OUT, RF_Bus, MEM_Addr, MEM_WData;
    logic        MEM_Ack = 1'b0;
    logic [15:0] MEM_RData = 16'd0;

    reg_ctx_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Base(Base),
        .Busy(Busy), .Done(Done), .RF_SR1(RF_SR1), .RF_SR1_OUT(RF_SR1_OUT),
        .RF_LD(RF_LD), .RF_DR(RF_DR), .RF_Bus(RF_Bus),
        .MEM_Req(MEM_Req), .MEM_WE(MEM_WE), .MEM_Addr(MEM_Addr),
        .MEM_WData(MEM_WData), .MEM_Ack(MEM_Ack), .MEM_RData(MEM_RData),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // register file model
    logic [15:0] rf [0:7];
    assign RF_SR1_OUT = rf[RF_SR1];
    always @(posedge Clk) if (RF_LD) rf[RF_DR] = RF_Bus;

    // memory responder and scoreboard: exp_q holds {we, addr, data}
    logic [15:0] mem [0:65535];
    logic [32:0] exp_q[$];
    logic [32:0] e;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        spur_ack = 1'b0;
    logic [15:0] last_addr = 16'd0;
    logic        prev_req = 1'b0, prev_we = 1'b0;
    logic [15:0] prev_addr = 16'd0, prev_wdata = 16'd0;

    always @(negedge Clk) begin
        if (!Reset && prev_req && MEM_Req && !MEM_Ack) begin
            chk("hold_addr", MEM_Addr, prev_addr);
            chk("hold_we", MEM_WE, prev_we);
            chk("hold_wdata", MEM_WData, prev_wdata);
        end
        prev_req = MEM_Req; prev_we = MEM_WE;
        prev_addr = MEM_Addr; prev_wdata = MEM_WData;
        if (Reset || !MEM_Req) begin
            MEM_Ack  = spur_ack && !Reset;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            MEM_Ack   = 1'b1;
            wait_cnt  = 0;
            last_addr = MEM_Addr;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_txn actual=%0h required=none", MEM_Addr);
            end else begin
                e = exp_q.pop_front();
                chk("txn_we", MEM_WE, e[32]);
                chk("txn_addr", MEM_Addr, e[31:16]);
                if (e[32]) chk("txn_wdata", MEM_WData, e[15:0]);
            end
            if (MEM_WE) mem[MEM_Addr] = MEM_WData;
            else MEM_RData = mem[MEM_Addr];
        end else begin
            MEM_Ack = 1'b0;
            wait_cnt++;
        end
    end

    // driver: one operation, counting busy cycles and Done pulses
    task automatic run_op(input logic mode, input logic [15:0] base, input int delay,
                          input logic noise, output int done_cyc, output int busy_cnt,
                          output int done_cnt, output logic ld_seen);
        ack_delay = delay;
        @(negedge Clk);
        Start = 1'b1; Mode = mode; Base = base;
        @(negedge Clk);
        Start = 1'b0;
        done_cyc = 0; busy_cnt = 0; done_cnt = 0; ld_seen = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (RF_LD) ld_seen = 1'b1;
            if (Done) begin
                done_cyc = cyc;
                done_cnt++;
                break;
            end
            if (Busy) busy_cnt++;
            if (noise) begin
                Start = 1'($urandom_range(0, 1));
                Mode  = ~mode;
                Base  = 16'($urandom_range(0, 65535));
            end
            @(negedge Clk);
        end
        Start = noise;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (Done) done_cnt++;
            if (Busy) busy_cnt++;
        end
    endtask

    typedef struct {
        logic        mode;
        logic [15:0] base;
        int          delay;
        logic        noise;
        logic [15:0] seed;
        int          exp_busy;
        int          exp_done;
        logic [15:0] exp_last;
    } vec_t;

    vec_t        vecs [5];
    int          dc, bc, nc;
    logic        ld;
    logic [15:0] a, d;
    int          got;

    initial begin
        vecs[0] = '{1'b0, 16'h3000, 0, 1'b0, 16'h1110,  8,  9, 16'h3007};
        vecs[1] = '{1'b1, 16'h4000, 3, 1'b0, 16'hA0A0, 40, 41, 16'h4007};
        vecs[2] = '{1'b0, 16'hFFFC, 0, 1'b0, 16'h1110,  8,  9, 16'h0003};
        vecs[3] = '{1'b1, 16'h4000, 0, 1'b0, 16'hB0B0, 16, 17, 16'h4007};
        vecs[4] = '{1'b0, 16'h1234, 2, 1'b1, 16'h2220, 24, 25, 16'h123B};
        for (int i = 0; i < 8; i++) rf[i] = 16'd0;

        // reset state
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Base = 16'd0;
        #12;
        chk("reset_outputs", {Busy, Done, RF_SR1, RF_LD, RF_DR, RF_Bus, MEM_Req, MEM_WE,
                              MEM_Addr, MEM_WData, dbg_state}, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // spurious ack in idle
        spur_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            chk("idle_ack_busy", Busy, 1'b0);
            chk("idle_ack_state", dbg_state, 3'd0);
            chk("idle_ack_req", MEM_Req, 1'b0);
        end
        spur_ack = 1'b0;

        // table-driven operations
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 8; i++) begin
                a = vecs[v].base + 16'(i);
                d = vecs[v].seed + 16'(i);
                if (!vecs[v].mode) rf[i] = d;
                else begin
                    rf[i]  = 16'd0;
                    mem[a] = d;
                end
                exp_q.push_back({~vecs[v].mode, a, d});
            end
            run_op(vecs[v].mode, vecs[v].base, vecs[v].delay, vecs[v].noise, dc, bc, nc, ld);
            chk($sformatf("v%0d_done_cycle", v), 64'(dc), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d_busy_cycles", v), 64'(bc), 64'(vecs[v].exp_busy));
            chk($sformatf("v%0d_done_pulses", v), 64'(nc), 64'd1);
            chk($sformatf("v%0d_last_addr", v), last_addr, vecs[v].exp_last);
            chk($sformatf("v%0d_rf_ld_seen", v), ld, vecs[v].mode);
            chk($sformatf("v%0d_txn_left", v), 64'(exp_q.size()), 64'd0);
            if (vecs[v].mode)
                for (int i = 0; i < 8; i++)
                    chk($sformatf("v%0d_r%0d", v, i), rf[i], vecs[v].seed + 16'(i));
            exp_q.delete();
        end

        // reset mid-restore after R2 is written
        for (int i = 0; i < 8; i++) begin
            rf[i] = 16'h5550 + 16'(i);
            mem[16'h4000 + 16'(i)] = 16'hA0A0 + 16'(i);
            exp_q.push_back({1'b0, 16'h4000 + 16'(i), 16'hA0A0 + 16'(i)});
        end
        ack_delay = 2;
        @(negedge Clk);
        Start = 1'b1; Mode = 1'b1; Base = 16'h4000;
        @(negedge Clk);
        Start = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (RF_LD && RF_DR == 3'd2) begin
                got = 1;
                break;
            end
            @(negedge Clk);
        end
        chk("rst_mid_reached_r2", 64'(got), 64'd1);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {Busy, Done, RF_SR1, RF_LD, RF_DR, RF_Bus, MEM_Req, MEM_WE,
                                MEM_Addr, MEM_WData, dbg_state}, 64'd0);
        nc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            if (Done || RF_LD) nc++;
        end
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            if (Done || RF_LD || Busy) nc++;
        end
        chk("rst_mid_quiet", 64'(nc), 64'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rst_mid_r%0d", i), rf[i],
                (i <= 2) ? 16'hA0A0 + 16'(i) : 16'h5550 + 16'(i));
        exp_q.delete();

        // back-to-back: Start in the idle cycle right after DONE
        for (int i = 0; i < 8; i++) rf[i] = 16'h1110 + 16'(i);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 16'h2000 + 16'(i), 16'h1110 + 16'(i)});
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 16'h2100 + 16'(i), 16'h1110 + 16'(i)});
        ack_delay = 0;
        @(negedge Clk);
        Start = 1'b1; Mode = 1'b0; Base = 16'h2000;
        @(negedge Clk);
        Start = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (Done) begin
                got = 1;
                break;
            end
            @(negedge Clk);
        end
        chk("b2b_first_done", 64'(got), 64'd1);
        @(negedge Clk);
        chk("b2b_idle_busy", Busy, 1'b0);
        Start = 1'b1; Base = 16'h2100;
        @(negedge Clk);
        Start = 1'b0;
        chk("b2b_busy", Busy, 1'b1);
        chk("b2b_addr", MEM_Addr, 16'h2100);
        got = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (Done) begin
                got = 1;
                break;
            end
            @(negedge Clk);
        end
        chk("b2b_second_done", 64'(got), 64'd1);
        @(negedge Clk);
        chk("b2b_txn_left", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
